// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game sequencer: random stimulus delay, millisecond response timing,
// and active-low seven-segment patterns for the four-digit display multiplexer.
module reaction_timer_ctrl #(
  parameter int          CLKS_PER_MS = 100000,
  parameter int          MIN_WAIT_MS = 2000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  output logic       led_o,
  output logic [7:0] in0_o,
  output logic [7:0] in1_o,
  output logic [7:0] in2_o,
  output logic [7:0] in3_o
);

  localparam int              PW        = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [13:0]     MIN_WAIT  = 14'(MIN_WAIT_MS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [PW-1:0] r_presc;
  logic [13:0]   r_wait;
  logic [13:0]   r_target;
  logic [15:0]   r_bcd;

  logic [1:0]    w_nextState;
  logic [13:0]   w_nextWait;
  logic [13:0]   w_nextTarget;
  logic [15:0]   w_nextBcd;
  logic [15:0]   w_bcdInc;
  logic [13:0]   w_waitInc;
  logic          w_tick;

  assign w_tick    = (r_presc == TICK_LAST);
  assign w_waitInc = r_wait + 14'd1;

  // Four-digit decimal increment with ripple carry; d3 only ever reaches 1 here.
  always_comb begin
    w_bcdInc = r_bcd;
    if (r_bcd[3:0] != 4'd9) begin
      w_bcdInc[3:0] = r_bcd[3:0] + 4'd1;
    end else begin
      w_bcdInc[3:0] = 4'd0;
      if (r_bcd[7:4] != 4'd9) begin
        w_bcdInc[7:4] = r_bcd[7:4] + 4'd1;
      end else begin
        w_bcdInc[7:4] = 4'd0;
        if (r_bcd[11:8] != 4'd9) begin
          w_bcdInc[11:8] = r_bcd[11:8] + 4'd1;
        end else begin
          w_bcdInc[11:8]  = 4'd0;
          w_bcdInc[15:12] = r_bcd[15:12] + 4'd1;
        end
      end
    end
  end

  // Priority: clear, then stop, then tick/target, then start.
  always_comb begin
    w_nextState  = r_state;
    w_nextWait   = r_wait;
    w_nextTarget = r_target;
    w_nextBcd    = r_bcd;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_nextState  = ST_WAIT;
          w_nextTarget = MIN_WAIT + {2'b00, r_lfsr[11:0]};
          w_nextWait   = 14'd0;
        end
      end
      ST_WAIT: begin
        if (clear_i) begin
          w_nextState = ST_IDLE;
        end else if (stop_i) begin
          w_nextState = ST_DONE;
          w_nextBcd   = 16'h9999;
        end else if (w_tick) begin
          w_nextWait = w_waitInc;
          if (w_waitInc == r_target) begin
            w_nextState = ST_MEASURE;
            w_nextBcd   = 16'h0000;
          end
        end
      end
      ST_MEASURE: begin
        if (clear_i) begin
          w_nextState = ST_IDLE;
        end else if (stop_i) begin
          w_nextState = ST_DONE;
        end else if (w_tick) begin
          w_nextBcd = w_bcdInc;
          if (w_bcdInc == 16'h1000) begin
            w_nextState = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (clear_i) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The prescaler restarts on every state entry so WAIT and MEASURE begin on a full millisecond.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_presc  <= '0;
      r_wait   <= 14'd0;
      r_target <= 14'd0;
      r_bcd    <= 16'h0000;
    end else begin
      r_state  <= w_nextState;
      r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_wait   <= w_nextWait;
      r_target <= w_nextTarget;
      r_bcd    <= w_nextBcd;
      if ((w_nextState != r_state) || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  function automatic logic [7:0] segOf(input logic [3:0] digit);
    case (digit)
      4'd0:    segOf = 8'hC0;
      4'd1:    segOf = 8'hF9;
      4'd2:    segOf = 8'hA4;
      4'd3:    segOf = 8'hB0;
      4'd4:    segOf = 8'h99;
      4'd5:    segOf = 8'h92;
      4'd6:    segOf = 8'h82;
      4'd7:    segOf = 8'hF8;
      4'd8:    segOf = 8'h80;
      4'd9:    segOf = 8'h90;
      default: segOf = 8'hFF;
    endcase
  endfunction

  always_comb begin
    led_o = (r_state == ST_MEASURE);
    in3_o = 8'hFF;
    in2_o = 8'hFF;
    in1_o = 8'hFF;
    in0_o = 8'hFF;
    case (r_state)
      ST_IDLE: begin
        in1_o = 8'h89;
        in0_o = 8'hF9;
      end
      ST_MEASURE, ST_DONE: begin
        in3_o = segOf(r_bcd[15:12]) & 8'h7F;
        in2_o = segOf(r_bcd[11:8]);
        in1_o = segOf(r_bcd[7:4]);
        in0_o = segOf(r_bcd[3:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomized self-checking bench for reaction_timer_ctrl (CLKS_PER_MS=4, MIN_WAIT_MS=2);
// expectations come from millisecond arithmetic and a free-running LFSR model.
module tb_reaction_timer_ctrl;

  localparam int          CLKS     = 4;
  localparam int          MINW     = 2;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [31:0] HI_DISP  = 32'hFFFF89F9;
  localparam logic [31:0] BLANK    = 32'hFFFFFFFF;
  localparam int          WAIT_CAP = 20000;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       led_o;
  logic [7:0] in0_o, in1_o, in2_o, in3_o;

  int nChecks = 0;
  int nPass = 0;
  logic [15:0] mLfsr;

  reaction_timer_ctrl #(
    .CLKS_PER_MS(CLKS),
    .MIN_WAIT_MS(MINW),
    .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .clear_i(clear_i),
    .led_o(led_o),
    .in0_o(in0_o),
    .in1_o(in1_o),
    .in2_o(in2_o),
    .in3_o(in3_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference LFSR: x^16+x^14+x^13+x^11 stepped once per clock from the seed.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mLfsr <= SEED;
    end else begin
      mLfsr <= 16'(({16'd0, mLfsr} << 1) | 32'(((mLfsr >> 15) ^ (mLfsr >> 13) ^ (mLfsr >> 12) ^ (mLfsr >> 10)) & 16'd1));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] segOf(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Display for a millisecond count shown as s.mmm with the decimal point after the seconds digit.
  function automatic logic [31:0] msDisp(input int v);
    return {segOf(v / 1000) & 8'h7F, segOf((v / 100) % 10), segOf((v / 10) % 10), segOf(v % 10)};
  endfunction

  function automatic logic [32:0] observed();
    return {led_o, in3_o, in2_o, in1_o, in0_o};
  endfunction

  task automatic applyStimulus(input bit doStart, input bit doStop, input bit doClear);
    start_i = doStart;
    stop_i  = doStop;
    clear_i = doClear;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i  = 1'b0;
    clear_i = 1'b0;
  endtask

  // From IDLE at a negedge: start, then count negedges spent with the LED off until it lights.
  task automatic startToMeasure(input bit pickSmall, output int waited, output int expected,
                                output bit sawNonBlank);
    int guard = 0;
    if (pickSmall) begin
      while (mLfsr[11:0] >= 12'd200 && guard < 3000) begin
        @(negedge clk_i);
        guard++;
      end
    end
    expected = CLKS * (MINW + int'(mLfsr[11:0]));
    applyStimulus(1'b1, 1'b0, 1'b0);
    waited = 0;
    sawNonBlank = 1'b0;
    while (led_o === 1'b0 && waited < WAIT_CAP) begin
      if ({in3_o, in2_o, in1_o, in0_o} !== BLANK) sawNonBlank = 1'b1;
      waited++;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL reset_held: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
    rst_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) applyStimulus(1'b0, 1'b1, 1'b0);
      else if (i == 8) applyStimulus(1'b0, 1'b0, 1'b1);
      else @(negedge clk_i);
      nChecks++;
      if (observed() !== {1'b0, HI_DISP})
        $display("[TB] FAIL idle_hold[%0d]: got %h expected %h", i, observed(), {1'b0, HI_DISP});
      else nPass++;
    end
  endtask

  task automatic test_wait_duration();
    int waited, expected;
    bit sawNonBlank;
    startToMeasure(1'b0, waited, expected, sawNonBlank);
    nChecks++;
    if (waited !== expected)
      $display("[TB] FAIL wait_cycles: got %0d expected %0d", waited, expected);
    else nPass++;
    nChecks++;
    if (sawNonBlank !== 1'b0)
      $display("[TB] FAIL wait_blank: got nonblank=%0b expected 0", sawNonBlank);
    else nPass++;
    nChecks++;
    if (observed() !== {1'b1, msDisp(0)})
      $display("[TB] FAIL measure_entry: got %h expected %h", observed(), {1'b1, msDisp(0)});
    else nPass++;
  endtask

  // Called right after test_wait_duration, one negedge after MEASURE entry.
  task automatic test_stop_37();
    repeat (4 * 37 + 1) @(negedge clk_i);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      nChecks++;
      if (observed() !== {1'b0, 32'h40C0B0F8})
        $display("[TB] FAIL done_037[%0d]: got %h expected %h", i, observed(), {1'b0, 32'h40C0B0F8});
      else nPass++;
      applyStimulus(i == 2, i == 5, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL clear_after_done: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
  endtask

  task automatic test_early_press();
    int k;
    k = $urandom_range(0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (k) @(negedge clk_i);
    applyStimulus(1'b0, 1'b1, 1'b0);
    nChecks++;
    if (observed() !== {1'b0, 32'h10909090})
      $display("[TB] FAIL early_press: got %h expected %h", observed(), {1'b0, 32'h10909090});
    else nPass++;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b0, 32'h10909090})
      $display("[TB] FAIL early_start_ignored: got %h expected %h", observed(), {1'b0, 32'h10909090});
    else nPass++;
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL early_clear: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (k) @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 1'b1);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL wait_clear: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
  endtask

  task automatic test_timeout();
    int waited, expected;
    bit sawNonBlank;
    startToMeasure(1'b1, waited, expected, sawNonBlank);
    nChecks++;
    if (waited !== expected)
      $display("[TB] FAIL timeout_wait_cycles: got %0d expected %0d", waited, expected);
    else nPass++;
    repeat (1000 * CLKS - 1) @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b1, msDisp(999)})
      $display("[TB] FAIL before_timeout: got %h expected %h", observed(), {1'b1, msDisp(999)});
    else nPass++;
    @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b0, 32'h79C0C0C0})
      $display("[TB] FAIL timeout: got %h expected %h", observed(), {1'b0, 32'h79C0C0C0});
    else nPass++;
    repeat (2 * CLKS) @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b0, 32'h79C0C0C0})
      $display("[TB] FAIL timeout_hold: got %h expected %h", observed(), {1'b0, 32'h79C0C0C0});
    else nPass++;
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random_stop();
    int waited, expected, j, ms;
    bit sawNonBlank;
    for (int t = 0; t < 4; t++) begin
      startToMeasure(1'b1, waited, expected, sawNonBlank);
      nChecks++;
      if (waited !== expected)
        $display("[TB] FAIL rand_wait_cycles[%0d]: got %0d expected %0d", t, waited, expected);
      else nPass++;
      j = $urandom_range(1, 400);
      ms = (j - 1) / CLKS;
      repeat (j - 1) @(negedge clk_i);
      applyStimulus(1'b0, 1'b1, 1'b0);
      nChecks++;
      if (observed() !== {1'b0, msDisp(ms)})
        $display("[TB] FAIL rand_stop[%0d] j=%0d: got %h expected %h", t, j, observed(), {1'b0, msDisp(ms)});
      else nPass++;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_edge_cases();
    int waited, expected;
    bit sawNonBlank;
    startToMeasure(1'b1, waited, expected, sawNonBlank);
    repeat ($urandom_range(0, 20)) @(negedge clk_i);
    applyStimulus(1'b0, 1'b1, 1'b1);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL clear_and_stop: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;

    startToMeasure(1'b1, waited, expected, sawNonBlank);
    repeat (6 * CLKS - 1) @(negedge clk_i);
    applyStimulus(1'b0, 1'b1, 1'b0);
    nChecks++;
    if (observed() !== {1'b0, msDisp(5)})
      $display("[TB] FAIL stop_on_tick: got %h expected %h", observed(), {1'b0, msDisp(5)});
    else nPass++;
    applyStimulus(1'b0, 1'b0, 1'b1);

    startToMeasure(1'b1, waited, expected, sawNonBlank);
    repeat (10) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL async_reset: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    nChecks++;
    if (observed() !== {1'b0, HI_DISP})
      $display("[TB] FAIL after_reset: got %h expected %h", observed(), {1'b0, HI_DISP});
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_wait_duration();
    test_stop_37();
    test_early_press();
    test_timeout();
    test_random_stop();
    test_edge_cases();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
